// File: rtl/packed_lane_pipe.sv
// packed_lane_pipe: elastic multi-stage pipeline register for packed lane buses.
// Each stage has its own valid bit. Empty stages are refilled in the next cycle,
// so bubbles collapse. Masked input lanes are replaced by the RESET_VALUE lane.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   clear         synchronous flush, active-high; blocks input in the same cycle
//   in_valid      upstream payload valid
//   in_ready      stage 0 can accept (combinational)
//   in_data       upstream payload, [LANES-1:0][LANE_W-1:0]
//   in_lane_mask  per-lane select: 1 = in_data lane, 0 = RESET_VALUE lane
//   out_valid     last stage holds valid data
//   out_ready     downstream accepts
//   out_data      last-stage payload
//   occupancy     number of valid stages
module packed_lane_pipe #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 4,
  parameter int unsigned DEPTH  = 3,
  parameter logic [LANES-1:0][LANE_W-1:0] RESET_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES-1:0][LANE_W-1:0]      in_data,
  input  logic [LANES-1:0]                  in_lane_mask,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0][LANE_W-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef logic [LANES-1:0][LANE_W-1:0] word_t;

  logic [DEPTH-1:0]  v_q, v_n;
  word_t [DEPTH-1:0] d_q, d_n;
  logic [OCC_W-1:0]  occ_q, occ_n;

  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  up_v;
  word_t [DEPTH:0]   up_d;
  word_t             in_masked;
  logic              in_acc;

  // Per-lane substitution of the reset value for masked lanes.
  always_comb begin
    in_masked = RESET_VALUE;
    for (int k = 0; k < int'(LANES); k++) begin
      if (in_lane_mask[k]) begin
        in_masked[k] = in_data[k];
      end
    end
  end

  // Ready ripples backwards from the sink: a stage is ready if empty or its successor is.
  always_comb begin
    logic chain;
    chain = out_ready;
    rdy   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      chain  = ~v_q[i] | chain;
      rdy[i] = chain;
    end
  end

  assign in_ready = rdy[0] & ~clear;
  assign in_acc   = in_valid & in_ready;

  // Upstream view of each stage: index 0 is the (masked) input, index i is stage i-1.
  assign up_v = DEPTH'({v_q, in_acc});
  assign up_d = {d_q, in_masked};

  // Next-state for stage valids/data and the occupancy count.
  always_comb begin
    v_n   = v_q;
    d_n   = d_q;
    occ_n = '0;
    if (clear) begin
      v_n = '0;
      d_n = {DEPTH{RESET_VALUE}};
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (rdy[i]) begin
          v_n[i] = up_v[i];
          if (up_v[i]) begin
            d_n[i] = up_d[i];
          end
        end
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_n = occ_n + OCC_W'(v_n[i]);
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q   <= '0;
      d_q   <= {DEPTH{RESET_VALUE}};
      occ_q <= '0;
    end else begin
      v_q   <= v_n;
      d_q   <= d_n;
      occ_q <= occ_n;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_packed_lane_pipe.sv
// Directed testbench for packed_lane_pipe (LANES=8, LANE_W=4, DEPTH=3).
module tb_packed_lane_pipe;

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned DEPTH  = 3;
  localparam logic [31:0] RV     = 32'h89AB_CDEF;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         clear;
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0][LANE_W-1:0] in_data;
  logic [LANES-1:0]             in_lane_mask;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES-1:0][LANE_W-1:0] out_data;
  logic [1:0]                   occupancy;

  int tests_run    = 0;
  int tests_failed = 0;

  packed_lane_pipe #(
    .LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_lane_mask(in_lane_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then report what the next rising edge will do.
  task automatic step(input logic iv, input logic [31:0] d, input logic [7:0] m,
                      input logic ordy, input logic clr,
                      output logic acc, output logic ox, output logic [31:0] od);
    @(negedge clk);
    in_valid     = iv;
    in_data      = d;
    in_lane_mask = m;
    out_ready    = ordy;
    clear        = clr;
    #1;
    acc = in_valid & in_ready;
    ox  = out_valid & out_ready;
    od  = out_data;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_lane_mask = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_data !== RV) begin tests_failed++; $display("FAIL reset_out_data: got %h expected %h", out_data, RV); end
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream();
    logic acc, ox;
    logic [31:0] od;
    int nout = 0, first = -1, last = -1;
    for (int c = 0; c < 16; c++) begin
      step(c < 10, 32'(c + 1), 8'hFF, 1'b1, 1'b0, acc, ox, od);
      if (c < 10) begin
        tests_run++;
        if (acc !== 1'b1) begin tests_failed++; $display("FAIL stream_accept: cycle %0d got %b expected 1", c, acc); end
      end
      if (ox) begin
        tests_run++;
        if (od !== 32'(nout + 1)) begin tests_failed++; $display("FAIL stream_data: got %h expected %h", od, 32'(nout + 1)); end
        if (first < 0) first = c;
        last = c;
        nout++;
      end
      if (c >= 3 && c <= 10) begin
        tests_run++;
        if (occupancy !== 2'd3) begin tests_failed++; $display("FAIL stream_occupancy: cycle %0d got %0d expected 3", c, occupancy); end
      end
    end
    tests_run++;
    if (first != 3) begin tests_failed++; $display("FAIL stream_latency: got %0d expected 3", first); end
    tests_run++;
    if (nout != 10) begin tests_failed++; $display("FAIL stream_count: got %0d expected 10", nout); end
    tests_run++;
    if (last != 12) begin tests_failed++; $display("FAIL stream_gapless: last at %0d expected 12", last); end
  endtask

  task automatic test_backpressure();
    logic acc, ox;
    logic [31:0] od;
    int next = 0, nout = 0, first = -1, last = -1;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 32'h11 + 32'(next), 8'hFF, 1'b0, 1'b0, acc, ox, od);
      if (acc) next++;
      if (c >= 3) begin
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", c, in_ready); end
        tests_run++;
        if (occupancy !== 2'd3) begin tests_failed++; $display("FAIL bp_occupancy: got %0d expected 3", occupancy); end
        tests_run++;
        if (out_data !== 32'h11 || out_valid !== 1'b1) begin
          tests_failed++; $display("FAIL bp_hold: got %h/%b expected 00000011/1", out_data, out_valid);
        end
      end
    end
    tests_run++;
    if (next != 3) begin tests_failed++; $display("FAIL bp_accepts: got %0d expected 3", next); end
    for (int c = 0; c < 10; c++) begin
      step(next < 5, 32'h11 + 32'(next), 8'hFF, 1'b1, 1'b0, acc, ox, od);
      if (acc) next++;
      if (ox) begin
        tests_run++;
        if (od !== 32'h11 + 32'(nout)) begin tests_failed++; $display("FAIL bp_drain_data: got %h expected %h", od, 32'h11 + 32'(nout)); end
        if (first < 0) first = c;
        last = c;
        nout++;
      end
    end
    tests_run++;
    if (nout != 5 || first != 0 || last != 4) begin
      tests_failed++; $display("FAIL bp_drain_order: got count %0d span %0d..%0d expected 5 span 0..4", nout, first, last);
    end
  endtask

  task automatic test_mask();
    logic acc, ox;
    logic [31:0] od;
    int nout = 0;
    step(1'b1, 32'h1234_5678, 8'b1111_0000, 1'b1, 1'b0, acc, ox, od);
    tests_run++;
    if (acc !== 1'b1) begin tests_failed++; $display("FAIL mask_accept: got %b expected 1", acc); end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, acc, ox, od);
      if (ox) begin
        tests_run++;
        if (od !== 32'h1234_CDEF) begin tests_failed++; $display("FAIL mask_data: got %h expected 1234cdef", od); end
        nout++;
      end
    end
    tests_run++;
    if (nout != 1) begin tests_failed++; $display("FAIL mask_count: got %0d expected 1", nout); end
  endtask

  task automatic test_clear();
    logic acc, ox;
    logic [31:0] od;
    int nout = 0;
    step(1'b1, 32'h21, 8'hFF, 1'b0, 1'b0, acc, ox, od);
    step(1'b1, 32'h22, 8'hFF, 1'b0, 1'b0, acc, ox, od);
    step(1'b1, 32'h23, 8'hFF, 1'b0, 1'b1, acc, ox, od);
    tests_run++;
    if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL clear_pre_occupancy: got %0d expected 2", occupancy); end
    tests_run++;
    if (acc !== 1'b0) begin tests_failed++; $display("FAIL clear_in_ready: got %b expected 0", acc); end
    step(1'b0, 32'h0, 8'hFF, 1'b0, 1'b0, acc, ox, od);
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL clear_occupancy: got %0d expected 0", occupancy); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL clear_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_data !== RV) begin tests_failed++; $display("FAIL clear_out_data: got %h expected %h", out_data, RV); end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 32'h0, 8'hFF, 1'b1, 1'b0, acc, ox, od);
      if (ox) nout++;
    end
    tests_run++;
    if (nout != 0) begin tests_failed++; $display("FAIL clear_no_output: got %0d outputs expected 0", nout); end
  endtask

  task automatic test_async_reset();
    logic acc, ox;
    logic [31:0] od;
    int nout = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 32'h51 + 32'(c), 8'hFF, 1'b1, 1'b0, acc, ox, od);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL areset_occupancy: got %0d expected 0", occupancy); end
    tests_run++;
    if (out_data !== RV) begin tests_failed++; $display("FAIL areset_out_data: got %h expected %h", out_data, RV); end
    #1 reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(c < 3, 32'hA1 + 32'(c), 8'hFF, 1'b1, 1'b0, acc, ox, od);
      if (ox) begin
        tests_run++;
        if (od !== 32'hA1 + 32'(nout)) begin tests_failed++; $display("FAIL areset_resume_data: got %h expected %h", od, 32'hA1 + 32'(nout)); end
        nout++;
      end
    end
    tests_run++;
    if (nout != 3) begin tests_failed++; $display("FAIL areset_resume_count: got %0d expected 3", nout); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_mask();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/packed_lane_pipe.md
Name: packed_lane_pipe

Overview:
- Parametrised elastic pipeline register for packed multi-lane buses, organised as [LANES-1:0][LANE_W-1:0].
- DEPTH stages, each with its own valid bit and valid/ready flow control; bubbles collapse.
- Per-lane input masking substitutes the lane's RESET_VALUE slice.
- Synchronous clear plus an occupancy count; used wherever packed lane data must be retimed across several cycles under backpressure.

Parameters:
- LANES, 8, number of lanes in the packed bus (>=1).
- LANE_W, 4, bits per lane (>=1).
- DEPTH, 3, number of register stages (>=1).
- RESET_VALUE, all zeros, packed [LANES-1:0][LANE_W-1:0]; stage data value after reset and clear, and the masked-lane substitute.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; asserted when 0.
- clear  input  1  synchronous flush, active-high.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage 0 can accept.
- in_data  input  [LANES-1:0][LANE_W-1:0]  upstream payload.
- in_lane_mask  input  LANES  1 = take the in_data lane; 0 = take the RESET_VALUE lane.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts.
- out_data  output  [LANES-1:0][LANE_W-1:0]  last-stage payload.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (reset=0, asynchronous):
  - all stage valids = 0; all stage data = RESET_VALUE; occupancy = 0.
  - out_valid = 0; out_data = RESET_VALUE; in_ready = 1 once reset is released.
- Stage i register: valid v[i], data d[i]. Stage DEPTH is the downstream sink, with ready r[DEPTH] = out_ready.
- Stage ready: r[i] = !v[i] | r[i+1]. This is combinational; in_ready = r[0] & !clear.
- Stage i loads when r[i]=1:
  - v[i] <= upstream valid (v[i-1], or in_valid for i=0).
  - d[i] <= upstream data only if upstream valid=1; otherwise d[i] holds.
- Input lane substitution at stage 0: lane k = in_lane_mask[k] ? in_data[k] : RESET_VALUE[k].
- Handshakes: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - in_data and in_lane_mask are sampled only on an input transfer.
- Latency: DEPTH cycles from input transfer to out_valid when unstalled. Throughput is 1 per cycle with out_ready held high.
- Backpressure:
  - out_ready=0 fills stages from the output back.
  - in_ready falls only when all DEPTH stages are valid.
  - Any empty stage is filled in the next cycle (bubble collapse).
- Ordering: strict FIFO. No data is dropped or duplicated except by clear or reset.
- out_data = d[DEPTH-1]. It holds its last value while out_valid=0, and is stable while out_valid=1 and out_ready=0.
- occupancy = popcount(v) after each edge. Range 0..DEPTH; full when occupancy=DEPTH.
- Clear (synchronous, at the sampling edge):
  - all v <= 0; all d <= RESET_VALUE; occupancy 0.
  - in_ready = 0 in that cycle, so a simultaneous in_valid is not accepted.
  - the output transfer in that cycle still completes if out_valid & out_ready.
- Reset asserted mid-transfer: immediate flush as above; in-flight data is lost.
- DEPTH=1 is legal: a single register with in_ready = !v[0] | out_ready.
- No width arithmetic other than occupancy; RESET_VALUE width must equal LANES*LANE_W.

Test Plan:
- Reset release with LANES=8, LANE_W=4, RESET_VALUE=32'h89AB_CDEF -> out_valid=0, out_data=32'h89AB_CDEF, occupancy=0, in_ready=1.
- Stream 32'h0000_0001..32'h0000_000A with mask 8'hFF and out_ready=1 -> the first out_valid appears 3 cycles after the first transfer; 10 consecutive outputs in order; occupancy steady at 3.
- Hold out_ready=0 and drive 5 inputs -> in_ready drops after 3 accepts, occupancy=3, out_data=first word and stable. Raise out_ready -> remaining words drain in order with no gaps.
- Send 32'h1234_5678 with mask 8'b1111_0000 and RESET_VALUE=32'h89AB_CDEF -> output 32'h1234_CDEF.
- With 2 stages valid, assert clear together with in_valid -> next cycle occupancy=0, out_valid=0, out_data=RESET_VALUE, and the input is not accepted.
- Pulse reset low mid-stream for less than 1 cycle, asynchronously -> immediate flush with outputs at reset values; streaming resumes correctly afterwards.
